uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader.sv | 190 +++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART receiver feeding a little-endian word assembler that writes a program
// image into memory and releases the core once the end marker arrives.
module uart_prog_loader #(
  parameter int CLK_HZ = 50000000,
  parameter int BIT_RATE = 9600,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W = 8,
  parameter logic [8*WORD_BYTES-1:0] END_WORD = '1,
  parameter int END_COUNT = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic [7:0]              uart_rx_data,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_break,
  output logic                    frame_err,
  output logic                    write_done,
  output logic                    overflow,
  output logic                    core_rstn,
  output logic [ADDR_W:0]         word_count
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CNT_W = $clog2(CPB) + 1;
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);
  localparam logic [BW-1:0] LAST_B = BW'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_A = '1;
  localparam logic [2:0] END_N = 3'(END_COUNT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic valid_q, valid_d;
  logic brk_q, brk_d;
  logic ferr_q, ferr_d;
  logic [BW-1:0] b_q, b_d;
  logic [8*WORD_BYTES-1:0] wdata_q, wdata_d;
  logic we_q, we_d;
  logic [ADDR_W:0] wc_q, wc_d;
  logic [2:0] endc_q, endc_d;
  logic done_q, done_d;
  logic ovf_q, ovf_d;
  logic crst_q;

  logic rx, fall, tick;

  assign rx = sync_q[1];
  assign fall = prev_q & ~rx;
  assign tick = (state_q == START) ? (cnt_q == HALF_M1)
                                   : (cnt_q == FULL_M1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      brk_q   <= 1'b0;
      ferr_q  <= 1'b0;
      b_q     <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wc_q    <= '0;
      endc_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      crst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], uart_rxd};
      prev_q  <= rx;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      brk_q   <= brk_d;
      ferr_q  <= ferr_d;
      b_q     <= b_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wc_q    <= wc_d;
      endc_q  <= endc_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      crst_q  <= done_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (uart_rx_en && fall) state_d = START;
      START: if (tick) state_d = rx ? IDLE : DATA;
      DATA:  if (tick && bit_q == 3'd7) state_d = STOP;
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    brk_d   = 1'b0;
    ferr_d  = 1'b0;
    if (state_q == START) bit_d = '0;
    if (state_q == DATA && tick) begin
      sh_d  = {rx, sh_q[7:1]};
      bit_d = bit_q + 3'd1;
    end
    if (state_q == STOP && tick) begin
      if (rx) begin
        valid_d = 1'b1;
        data_d  = sh_q;
      end else if (sh_q == 8'h00) begin
        brk_d = 1'b1;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  always_comb begin
    b_d     = b_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    wc_d    = wc_q;
    endc_d  = endc_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    if (valid_q && !done_q) begin
      wdata_d[8*b_q +: 8] = data_q;
      if (b_q == LAST_B) we_d = 1'b1;
      else b_d = b_q + BW'(1);
    end
    if (we_q) begin
      wc_d = wc_q + (ADDR_W+1)'(1);
      b_d  = '0;
      if (wdata_q == END_WORD) begin
        endc_d = endc_q + 3'd1;
        if (endc_q + 3'd1 == END_N) done_d = 1'b1;
      end else begin
        endc_d = '0;
      end
      // Last address without a terminating marker: stop rather than wrap.
      if (wc_q[ADDR_W-1:0] == LAST_A && !done_d) begin
        ovf_d  = 1'b1;
        done_d = 1'b1;
      end
    end
    if (brk_q && !done_q) begin
      b_d    = '0;
      wc_d   = '0;
      endc_d = '0;
    end
  end

  assign mem_we        = we_q;
  assign mem_addr      = wc_q[ADDR_W-1:0];
  assign mem_wdata     = wdata_q;
  assign uart_rx_data  = data_q;
  assign uart_rx_valid = valid_q;
  assign uart_rx_break = brk_q;
  assign frame_err     = ferr_q;
  assign write_done    = done_q;
  assign overflow      = ovf_q;
  assign core_rstn     = crst_q;
  assign word_count    = wc_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench: expected bytes, events and writes are queued at stimulus
// time; a negedge monitor pops and compares whenever the DUT pulses.
module tb_uart_prog_loader;

  localparam int CPB = 64;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0;
  logic rxd = 1'b1;
  logic en_a = 1'b1, en_b = 1'b0;
  logic sel_b = 1'b0;

  logic we_a, val_a, brk_a, ferr_a, done_a, ovf_a, crst_a;
  logic [7:0] addr_a, data_a;
  logic [31:0] wd_a;
  logic [8:0] wc_a;

  logic we_b, val_b, brk_b, ferr_b, done_b, ovf_b, crst_b;
  logic [1:0] addr_b;
  logic [7:0] data_b;
  logic [31:0] wd_b;
  logic [2:0] wc_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_rx_a[$];
  logic [7:0]  exp_rx_b[$];
  logic [39:0] exp_wr_a[$];
  logic [39:0] exp_wr_b[$];
  int          exp_ev_a[$];

  always #5 clk = ~clk;

  uart_prog_loader #(.CLK_HZ(640), .BIT_RATE(10)) dut_a (
    .clk(clk), .resetn(rst_a), .uart_rxd(rxd), .uart_rx_en(en_a),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .uart_rx_data(data_a), .uart_rx_valid(val_a),
    .uart_rx_break(brk_a), .frame_err(ferr_a),
    .write_done(done_a), .overflow(ovf_a), .core_rstn(crst_a),
    .word_count(wc_a)
  );

  uart_prog_loader #(.CLK_HZ(640), .BIT_RATE(10), .ADDR_W(2)) dut_b (
    .clk(clk), .resetn(rst_b), .uart_rxd(rxd), .uart_rx_en(en_b),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .uart_rx_data(data_b), .uart_rx_valid(val_b),
    .uart_rx_break(brk_b), .frame_err(ferr_b),
    .write_done(done_b), .overflow(ovf_b), .core_rstn(crst_b),
    .word_count(wc_b)
  );

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] eb;
    logic [39:0] ew;
    int ev;
    if (val_a) begin
      checks++;
      if (exp_rx_a.size() == 0) begin
        errors++;
        $display("FAIL rx_a got %h want none", data_a);
      end else begin
        eb = exp_rx_a.pop_front();
        if (data_a !== eb) begin
          errors++;
          $display("FAIL rx_a got %h want %h", data_a, eb);
        end
      end
    end
    if (we_a) begin
      checks++;
      if (exp_wr_a.size() == 0) begin
        errors++;
        $display("FAIL wr_a got %h:%h want none", addr_a, wd_a);
      end else begin
        ew = exp_wr_a.pop_front();
        if ({addr_a, wd_a} !== ew) begin
          errors++;
          $display("FAIL wr_a got %h:%h want %h", addr_a, wd_a, ew);
        end
      end
    end
    if (brk_a || ferr_a) begin
      checks++;
      if (exp_ev_a.size() == 0) begin
        errors++;
        $display("FAIL ev_a got brk=%0b ferr=%0b want none", brk_a, ferr_a);
      end else begin
        ev = exp_ev_a.pop_front();
        if ({brk_a, ferr_a} !== ((ev == 1) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL ev_a got brk=%0b ferr=%0b want code %0d",
                   brk_a, ferr_a, ev);
        end
      end
    end
    if (val_b) begin
      checks++;
      if (exp_rx_b.size() == 0) begin
        errors++;
        $display("FAIL rx_b got %h want none", data_b);
      end else begin
        eb = exp_rx_b.pop_front();
        if (data_b !== eb) begin
          errors++;
          $display("FAIL rx_b got %h want %h", data_b, eb);
        end
      end
    end
    if (we_b) begin
      checks++;
      if (exp_wr_b.size() == 0) begin
        errors++;
        $display("FAIL wr_b got %h:%h want none", addr_b, wd_b);
      end else begin
        ew = exp_wr_b.pop_front();
        if ({6'd0, addr_b, wd_b} !== ew) begin
          errors++;
          $display("FAIL wr_b got %h:%h want %h", addr_b, wd_b, ew);
        end
      end
    end
    if (brk_b || ferr_b) begin
      checks++;
      errors++;
      $display("FAIL ev_b got brk=%0b ferr=%0b want none", brk_b, ferr_b);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clk(CPB);
    end
    rxd = stop;
    wait_clk(CPB);
    rxd = 1'b1;
    wait_clk(2 * CPB);
  endtask

  task automatic send_byte(input logic [7:0] d);
    if (sel_b) exp_rx_b.push_back(d);
    else exp_rx_a.push_back(d);
    send_frame(d, 1'b1);
  endtask

  task automatic send_word(input logic [7:0] a, input logic [31:0] w,
                           input bit expect_wr);
    if (expect_wr) begin
      if (sel_b) exp_wr_b.push_back({a, w});
      else exp_wr_a.push_back({a, w});
    end
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_reset_a();
    @(negedge clk);
    rst_a = 1'b0;
    wait_clk(4);
    rst_a = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    wait_clk(5);
    check("rst_a_out", {we_a, val_a, brk_a, ferr_a, done_a, ovf_a, crst_a},
          64'd0);
    check("rst_a_data", {addr_a, data_a, wd_a, wc_a}, 64'd0);
    rst_a = 1'b1;
    wait_clk(4);

    send_word(8'd0, 32'hFE010113, 1'b1);
    check("s1_wc", wc_a, 64'd1);
    check("s1_done", done_a, 64'd0);

    pulse_reset_a();
    check("s2_wc_rst", wc_a, 64'd0);
    send_word(8'd0, 32'hFE010113, 1'b1);
    send_word(8'd1, 32'h00812E23, 1'b1);
    send_word(8'd2, 32'hFFFFFFFF, 1'b1);
    check("s2_done_mid", done_a, 64'd0);
    send_word(8'd3, 32'hFFFFFFFF, 1'b1);
    check("s2_done", {done_a, crst_a, ovf_a}, 64'b110);
    check("s2_wc", wc_a, 64'd4);
    send_byte(8'hAA);
    check("s2_wc_after", wc_a, 64'd4);

    pulse_reset_a();
    check("s3_rst", {done_a, crst_a}, 64'd0);
    @(negedge clk);
    rxd = 1'b0;
    wait_clk(12);
    rxd = 1'b1;
    wait_clk(3 * CPB);
    check("s3_idle", 64'(dut_a.state_q), 64'd0);
    check("s3_wc", wc_a, 64'd0);

    exp_ev_a.push_back(2);
    send_frame(8'h55, 1'b0);
    send_word(8'd0, 32'hDEADBEEF, 1'b1);
    check("s4_wc", wc_a, 64'd1);

    pulse_reset_a();
    send_byte(8'hA1);
    send_byte(8'hA2);
    exp_ev_a.push_back(1);
    send_frame(8'h00, 1'b0);
    check("s5_wc_brk", wc_a, 64'd0);
    send_word(8'd0, 32'h44332211, 1'b1);
    check("s5_wc", wc_a, 64'd1);

    en_a = 1'b0;
    send_frame(8'h77, 1'b1);
    check("s6_en_wc", wc_a, 64'd1);

    sel_b = 1'b1;
    rst_b = 1'b1;
    en_b = 1'b1;
    wait_clk(4);
    send_word(8'd0, 32'h03020100, 1'b1);
    send_word(8'd1, 32'h07060504, 1'b1);
    send_word(8'd2, 32'h0B0A0908, 1'b1);
    check("ov_mid", {done_b, ovf_b}, 64'd0);
    send_word(8'd3, 32'h0F0E0D0C, 1'b1);
    check("ov_flags", {done_b, ovf_b, crst_b}, 64'b111);
    check("ov_wc", wc_b, 64'd4);

    @(negedge clk);
    rxd = 1'b0;
    wait_clk(CPB);
    rxd = 1'b1;
    wait_clk(3 * CPB);
    rst_b = 1'b0;
    wait_clk(3);
    check("rb_out", {we_b, val_b, brk_b, ferr_b, done_b, ovf_b, crst_b},
          64'd0);
    check("rb_data", {addr_b, data_b, wd_b, wc_b}, 64'd0);
    check("rb_idle", 64'(dut_b.state_q), 64'd0);
    wait_clk(3 * CPB);
    rst_b = 1'b1;
    wait_clk(4);
    send_byte(8'h5A);
    check("rb_after", {done_b, ovf_b, wc_b}, 64'd0);

    wait_clk(10);
    check("q_rx_a", exp_rx_a.size(), 64'd0);
    check("q_wr_a", exp_wr_a.size(), 64'd0);
    check("q_ev_a", exp_ev_a.size(), 64'd0);
    check("q_rx_b", exp_rx_b.size(), 64'd0);
    check("q_wr_b", exp_wr_b.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
